// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60 from a 100 MHz system clock) and
// helper constants used by the scan controller and its pixel-tick divider.
package vga_pkg;

    localparam int SYS_CLK_HZ    = 100_000_000;
    localparam int PIX_CLK_HZ    = 25_000_000;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam bit DEF_HSYNC_POL = 1'b0;
    localparam bit DEF_VSYNC_POL = 1'b0;

    localparam int DEF_CLK_DIV   = SYS_CLK_HZ / PIX_CLK_HZ;
    localparam int DEF_COLOR_W   = 8;

    localparam int DEF_H_TOTAL   = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL   = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Counter width able to hold 0..total-1, never narrower than one bit.
    function automatic int cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 and pulses tick for one clock on the
// last count. With CLK_DIV==1 the counter stays at 0, so tick is constantly high.
module pix_tick_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster scan: x/y counters advanced at the pixel rate, combinational
// position decodes, and pixel-aligned registered colour and sync outputs.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit HSYNC_POL = DEF_HSYNC_POL,
    parameter bit VSYNC_POL = DEF_VSYNC_POL,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int COLOR_W   = DEF_COLOR_W,
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int XW       = cnt_w(H_TOTAL),
    localparam int YW       = cnt_w(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] pixel_rgb,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               pix_tick,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [COLOR_W-1:0] vga_color,
    output logic               hsync,
    output logic               vsync
);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;

    logic               tick;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               in_active, in_hsync, in_vsync;

    pix_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Region decodes compare in 32-bit space so a sync end equal to TOTAL cannot wrap.
    assign in_active = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
    assign in_hsync  = (int'(x_q) >= HS_START) && (int'(x_q) < HS_END);
    assign in_vsync  = (int'(y_q) >= VS_START) && (int'(y_q) < VS_END);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            color_d = in_active ? pixel_rgb : '0;
            hsync_d = in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync_d = in_vsync ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_tick    = tick;
    assign active      = in_active;
    assign line_start  = tick && (x_q == '0);
    assign frame_start = tick && (x_q == '0) && (y_q == '0);
    assign vga_color   = color_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: several parameter sets run side by side, each
// checked cycle by cycle against a raster model derived from the timing rules.
module tb_vga_scan_controller;

    localparam int NC  = 5;
    localparam int RUN = 2500;

    // Config 0/1/2: tiny 14x7 raster; 3: default 640x480 @ CLK_DIV=1; 4: odd 9x7 raster.
    localparam int HA[NC] = '{8, 8, 8, 640, 5};
    localparam int HF[NC] = '{2, 2, 2, 16, 1};
    localparam int HS[NC] = '{2, 2, 2, 96, 2};
    localparam int HB[NC] = '{2, 2, 2, 48, 1};
    localparam int VA[NC] = '{4, 4, 4, 480, 3};
    localparam int VF[NC] = '{1, 1, 1, 10, 1};
    localparam int VS[NC] = '{1, 1, 1, 2, 2};
    localparam int VB[NC] = '{1, 1, 1, 33, 1};
    localparam int DV[NC] = '{2, 2, 1, 1, 3};
    localparam int HP[NC] = '{0, 1, 0, 0, 1};
    localparam int VP[NC] = '{0, 1, 0, 0, 0};

    typedef struct {
        bit          tick;
        int          x;
        int          y;
        bit          act;
        bit          ls;
        bit          fs;
        logic [7:0]  col;
        bit          hs;
        bit          vs;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a [NC];
    logic [7:0] prgb  [NC];
    logic [15:0] d_x  [NC];
    logic [15:0] d_y  [NC];
    logic       d_tick[NC];
    logic       d_act [NC];
    logic       d_ls  [NC];
    logic       d_fs  [NC];
    logic [7:0] d_col [NC];
    logic       d_hs  [NC];
    logic       d_vs  [NC];

    rec_t q[NC][$];
    int   checks   = 0;
    int   failures = 0;
    bit   run_en   = 1'b0;

    for (genvar g = 0; g < NC; g++) begin : g_cfg
        localparam int HT = HA[g] + HF[g] + HS[g] + HB[g];
        localparam int VT = VA[g] + VF[g] + VS[g] + VB[g];
        localparam int XW = $clog2(HT);
        localparam int YW = $clog2(VT);
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;

        vga_scan_controller #(
            .H_ACTIVE (HA[g]), .H_FRONT(HF[g]), .H_SYNC(HS[g]), .H_BACK(HB[g]),
            .V_ACTIVE (VA[g]), .V_FRONT(VF[g]), .V_SYNC(VS[g]), .V_BACK(VB[g]),
            .HSYNC_POL(1'(HP[g])), .VSYNC_POL(1'(VP[g])),
            .CLK_DIV  (DV[g]), .COLOR_W(8)
        ) dut (
            .clk        (clk),
            .rst        (rst_a[g]),
            .pixel_rgb  (prgb[g]),
            .x          (dx),
            .y          (dy),
            .pix_tick   (d_tick[g]),
            .active     (d_act[g]),
            .line_start (d_ls[g]),
            .frame_start(d_fs[g]),
            .vga_color  (d_col[g]),
            .hsync      (d_hs[g]),
            .vsync      (d_vs[g])
        );

        assign d_x[g] = 16'(dx);
        assign d_y[g] = 16'(dy);
    end

    function automatic int h_total(input int g);
        return HA[g] + HF[g] + HS[g] + HB[g];
    endfunction

    function automatic int v_total(input int g);
        return VA[g] + VF[g] + VS[g] + VB[g];
    endfunction

    task automatic check(input int g, input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL cfg%0d %s at %0t: got=%0h expected=%0h", g, nm, $time, got, exp);
        end
    endtask

    // Stimulus and reference model: position follows from cycles since reset.
    initial begin
        int   c    [NC];
        bit   rdone[NC];
        logic [7:0] m_col[NC];
        bit   m_hs [NC];
        bit   m_vs [NC];
        int   ht, vt, n, px, py, frame;
        bit   tk, act, in_h, in_v, rr;
        logic [7:0] rgb;
        rec_t r;

        for (int g = 0; g < NC; g++) begin
            rst_a[g] = 1'b1;
            prgb[g]  = 8'h00;
            c[g]     = 0;
            rdone[g] = 1'b0;
            m_col[g] = 8'h00;
            m_hs[g]  = !HP[g][0];
            m_vs[g]  = !VP[g][0];
        end
        repeat (2) @(posedge clk);
        #1;
        run_en = 1'b1;
        for (int cyc = 0; cyc < RUN; cyc++) begin
            for (int g = 0; g < NC; g++) begin
                ht    = h_total(g);
                vt    = v_total(g);
                tk    = (c[g] % DV[g]) == (DV[g] - 1);
                n     = c[g] / DV[g];
                px    = n % ht;
                py    = (n / ht) % vt;
                frame = n / (ht * vt);
                act   = (px < HA[g]) && (py < VA[g]);
                in_h  = (px >= HA[g] + HF[g]) && (px < HA[g] + HF[g] + HS[g]);
                in_v  = (py >= VA[g] + VF[g]) && (py < VA[g] + VF[g] + VS[g]);
                // One mid-frame reset at x=5,y=2 of the second frame, landing on a tick.
                rr = (cyc == 0);
                if (g != 3 && !rdone[g] && tk && frame == 1 && px == 5 && py == 2) begin
                    rr       = 1'b1;
                    rdone[g] = 1'b1;
                end
                rgb      = (g == 0) ? 8'hA5 : 8'($urandom);
                rst_a[g] = rr;
                prgb[g]  = rgb;
                r.tick = tk;
                r.x    = px;
                r.y    = py;
                r.act  = act;
                r.ls   = tk && px == 0;
                r.fs   = tk && px == 0 && py == 0;
                r.col  = m_col[g];
                r.hs   = m_hs[g];
                r.vs   = m_vs[g];
                q[g].push_back(r);
                if (rr) begin
                    c[g]     = 0;
                    m_col[g] = 8'h00;
                    m_hs[g]  = !HP[g][0];
                    m_vs[g]  = !VP[g][0];
                end else begin
                    if (tk) begin
                        m_col[g] = act ? rgb : 8'h00;
                        m_hs[g]  = in_h ? HP[g][0] : !HP[g][0];
                        m_vs[g]  = in_v ? VP[g][0] : !VP[g][0];
                    end
                    c[g]++;
                end
            end
            @(posedge clk);
            #1;
        end
        run_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: pops the expected state for each cycle and compares mid-cycle.
    int gcyc = 0;
    int last_fs[NC];
    bit have_fs[NC] = '{default: 1'b0};

    always @(negedge clk) begin
        rec_t r;
        if (run_en) begin
            gcyc++;
            for (int g = 0; g < NC; g++) begin
                if (q[g].size() == 0) begin
                    check(g, "expected_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    r = q[g].pop_front();
                    check(g, "pix_tick", 32'(d_tick[g]), 32'(r.tick));
                    check(g, "x", 32'(d_x[g]), 32'(r.x));
                    check(g, "y", 32'(d_y[g]), 32'(r.y));
                    check(g, "active", 32'(d_act[g]), 32'(r.act));
                    check(g, "line_start", 32'(d_ls[g]), 32'(r.ls));
                    check(g, "frame_start", 32'(d_fs[g]), 32'(r.fs));
                    check(g, "vga_color", 32'(d_col[g]), 32'(r.col));
                    check(g, "hsync", 32'(d_hs[g]), 32'(r.hs));
                    check(g, "vsync", 32'(d_vs[g]), 32'(r.vs));
                end
                if (d_tick[g] === 1'b1 && d_fs[g] === 1'b1) begin
                    if (have_fs[g]) begin
                        check(g, "frame_period_clks", 32'(gcyc - last_fs[g]),
                              32'(h_total(g) * v_total(g) * DV[g]));
                    end
                    have_fs[g] = 1'b1;
                    last_fs[g] = gcyc;
                end
                if (rst_a[g] === 1'b1) begin
                    have_fs[g] = 1'b0;
                end
            end
        end
    end

endmodule
